// File: rtl/dnoc_rd_pkg.sv
// Shared types and default widths for the DNoC SRAM read agent.
package dnoc_rd_pkg;

    localparam int unsigned DefaultDw        = 128;
    localparam int unsigned DefaultAw        = 13;
    localparam int unsigned DefaultLenW      = 16;
    localparam int unsigned DefaultFifoDepth = 4;

    typedef enum logic [1:0] {
        StIdle,
        StInit,
        StRun,
        StDone
    } rd_state_e;

endpackage

// File: rtl/dnoc_sram_rd_agent_if.sv
// Generator, SRAM read port and output stream bundle of the read agent.
interface dnoc_sram_rd_agent_if #(
    parameter int unsigned DW = dnoc_rd_pkg::DefaultDw,
    parameter int unsigned AW = dnoc_rd_pkg::DefaultAw
);
    logic          addr_mu_initial_en;
    logic          addr_mu_valid;
    logic [AW-1:0] addr_mu_addr;
    logic          sram_rd_en;
    logic [AW-1:0] sram_rd_addr;
    logic [DW-1:0] sram_rd_data;
    logic          dout_valid;
    logic [DW-1:0] dout_data;
    logic          dout_last;
    logic          dout_ready;

    modport master (
        output addr_mu_initial_en, addr_mu_valid, sram_rd_en, sram_rd_addr,
        output dout_valid, dout_data, dout_last,
        input  addr_mu_addr, sram_rd_data, dout_ready
    );

    modport slave (
        input  addr_mu_initial_en, addr_mu_valid, sram_rd_en, sram_rd_addr,
        input  dout_valid, dout_data, dout_last,
        output addr_mu_addr, sram_rd_data, dout_ready
    );
endinterface

// File: rtl/dnoc_rd_fifo.sv
// Small synchronous FIFO; registered storage with a combinational head.
module dnoc_rd_fifo #(
    parameter int unsigned DW    = 128,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic [CW-1:0] cnt,
    output logic          empty,
    output logic          full
);
    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign cnt      = cnt_q;
    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CW'(DEPTH));

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));
endmodule

// File: rtl/dnoc_sram_rd_agent.sv
// Steps the loop address generator, reads the scratchpad and streams the data
// downstream with a last-beat marker and a completion pulse.
module dnoc_sram_rd_agent
    import dnoc_rd_pkg::*;
#(
    parameter int unsigned DW         = DefaultDw,
    parameter int unsigned AW         = DefaultAw,
    parameter int unsigned LEN_W      = DefaultLenW,
    parameter int unsigned FIFO_DEPTH = DefaultFifoDepth
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [LEN_W-1:0]        cfg_len,
    output logic                    busy,
    output logic                    done,
    dnoc_sram_rd_agent_if.master    bus
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    rd_state_e        state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] issue_cnt_q, issue_cnt_d;
    logic [LEN_W-1:0] out_cnt_q, out_cnt_d;
    logic             inflight_q;

    logic [CW-1:0] fifo_cnt;
    logic          fifo_empty, fifo_full;
    logic [DW-1:0] fifo_head;
    logic [CW:0]   occupancy;
    logic          credit_ok, issue, accept, is_last, out_valid;

    // Reads already in flight are counted so the returned beat always has a slot.
    assign occupancy = {1'b0, fifo_cnt} + (CW+1)'(inflight_q);
    assign credit_ok = (occupancy < (CW+1)'(FIFO_DEPTH)) && !fifo_full;
    assign is_last   = (out_cnt_q == len_q - LEN_W'(1));
    assign out_valid = rst_n && !fifo_empty;
    assign accept    = out_valid && bus.dout_ready;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        issue_cnt_d = issue_cnt_q;
        out_cnt_d   = out_cnt_q;
        issue       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StInit;
                    len_d       = cfg_len;
                    issue_cnt_d = '0;
                    out_cnt_d   = '0;
                end
            end
            StInit: state_d = (len_q == '0) ? StDone : StRun;
            StRun: begin
                issue = rst_n && (issue_cnt_q < len_q) && credit_ok;
                if (issue)  issue_cnt_d = issue_cnt_q + LEN_W'(1);
                if (accept) out_cnt_d   = out_cnt_q + LEN_W'(1);
                if (accept && is_last) state_d = StDone;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            len_q       <= '0;
            issue_cnt_q <= '0;
            out_cnt_q   <= '0;
            inflight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            issue_cnt_q <= issue_cnt_d;
            out_cnt_q   <= out_cnt_d;
            inflight_q  <= issue;
        end
    end

    dnoc_rd_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q && rst_n),
        .push_data (bus.sram_rd_data),
        .pop       (accept),
        .pop_data  (fifo_head),
        .cnt       (fifo_cnt),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Every output is gated so it reads 0 during the reset cycle itself.
    assign busy                   = rst_n && (state_q != StIdle);
    assign done                   = rst_n && (state_q == StDone);
    assign bus.addr_mu_initial_en = rst_n && (state_q == StInit);
    assign bus.addr_mu_valid      = issue;
    assign bus.sram_rd_en         = issue;
    assign bus.sram_rd_addr       = issue ? bus.addr_mu_addr : '0;
    assign bus.dout_valid         = out_valid;
    assign bus.dout_data          = out_valid ? fifo_head : '0;
    assign bus.dout_last          = out_valid && is_last;
endmodule

// File: tb/tb_dnoc_sram_rd_agent.sv
// Directed and randomized bench for dnoc_sram_rd_agent with generator and SRAM models.
module tb_dnoc_sram_rd_agent;
    localparam int unsigned DW = 128, AW = 13, LEN_W = 16, DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n, start, busy, done;
    logic [LEN_W-1:0] cfg_len;

    dnoc_sram_rd_agent_if #(.DW(DW), .AW(AW)) bus ();

    dnoc_sram_rd_agent #(
        .DW         (DW),
        .AW         (AW),
        .LEN_W      (LEN_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .cfg_len (cfg_len),
        .busy    (busy),
        .done    (done),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Generator model: address k of the programmed sequence after k steps.
    logic [AW-1:0] addr_seq [128];
    int            gen_idx;
    always @(posedge clk) begin
        if (!rst_n)                       gen_idx <= 0;
        else if (bus.addr_mu_initial_en)  gen_idx <= 0;
        else if (bus.addr_mu_valid)       gen_idx <= gen_idx + 1;
    end
    assign bus.addr_mu_addr = addr_seq[gen_idx & 127];

    // SRAM model: mem[a] = a, one cycle latency.
    always @(posedge clk) if (bus.sram_rd_en) bus.sram_rd_data <= DW'(bus.sram_rd_addr);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor, sampled on the falling edge; cycles are relative to the honoured start.
    logic [DW-1:0] beat_data [$];
    bit            beat_last [$];
    int            beat_cyc  [$];
    int            start_cyc, rd_cnt, init_cnt, done_cnt, done_cyc, last_busy_cyc;
    int            rd_total, acc_total, max_out, out_err, stab_err, pair_err, rd_at12;
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    bit            prev_last;

    task automatic mon_clear();
        beat_data.delete(); beat_last.delete(); beat_cyc.delete();
        rd_cnt = 0; init_cnt = 0; done_cnt = 0; done_cyc = -1; last_busy_cyc = -1;
        rd_total = 0; acc_total = 0; max_out = 0; out_err = 0; stab_err = 0; pair_err = 0;
        rd_at12 = -1; prev_stall = 0;
    endtask

    always @(negedge clk) begin
        int rel, outstanding;
        if (!rst_n) begin
            mon_clear();
        end else begin
            if (start && !busy) begin
                mon_clear();
                start_cyc = cyc;
            end
            rel = cyc - start_cyc;
            if (bus.addr_mu_initial_en) init_cnt++;
            if (bus.addr_mu_valid !== bus.sram_rd_en) pair_err++;
            outstanding = rd_total + int'(bus.sram_rd_en) - acc_total;
            if (outstanding > max_out) max_out = outstanding;
            if (outstanding > int'(DEPTH)) out_err++;
            if (bus.sram_rd_en) rd_cnt++;
            if (prev_stall && !(bus.dout_valid && bus.dout_data === prev_data
                                && bus.dout_last === prev_last)) stab_err++;
            if (bus.dout_valid && bus.dout_ready) begin
                beat_data.push_back(bus.dout_data);
                beat_last.push_back(bus.dout_last);
                beat_cyc.push_back(rel);
                acc_total++;
            end
            prev_stall = bus.dout_valid && !bus.dout_ready;
            prev_data  = bus.dout_data;
            prev_last  = bus.dout_last;
            if (done) begin done_cnt++; done_cyc = rel; end
            if (busy) last_busy_cyc = rel;
            rd_total += int'(bus.sram_rd_en);
            if (rel == 12) rd_at12 = rd_cnt;
        end
    end

    int n_checks = 0, n_err = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctrl"}, DW'({busy, done, bus.addr_mu_initial_en, bus.addr_mu_valid,
                                 bus.sram_rd_en, bus.sram_rd_addr, bus.dout_valid,
                                 bus.dout_last}), '0);
        chk({tag, "_data"}, bus.dout_data, '0);
    endtask

    function automatic bit ready_for(input int mode, input int rel);
        if (mode == 1) return !(rel >= 4 && rel <= 12);
        if (mode == 2) return $urandom_range(0, 3) != 0;
        return 1'b1;
    endfunction

    // Drives one transfer; abort >= 0 returns at that cycle without waiting for done.
    task automatic do_run(input string tag, input int len, input int mode, input bit restart,
                          input int abort);
        int rel = 0;
        bit finished = 0;
        while (rel < 400) begin
            if (rel == abort) return;
            start   = (rel == 0) || (restart && rel == 6);
            cfg_len = (rel == 0) ? LEN_W'(len) : (restart && rel == 6) ? LEN_W'(99)
                                               : LEN_W'($urandom);
            bus.dout_ready = ready_for(mode, rel);
            @(posedge clk); #1;
            rel++;
            if (done_cnt > 0) begin
                start = 1'b0;
                bus.dout_ready = 1'b1;
                repeat (3) begin @(posedge clk); #1; end
                finished = 1;
                break;
            end
        end
        start = 1'b0;
        chk({tag, "_completed"}, DW'(finished), DW'(1));
    endtask

    task automatic chk_beats(input string tag, input int len, input bit consec);
        chk({tag, "_n_beats"}, DW'(beat_data.size()), DW'(len));
        for (int k = 0; k < len && k < beat_data.size(); k++) begin
            chk($sformatf("%s_data%0d", tag, k), beat_data[k], DW'(addr_seq[k]));
            chk($sformatf("%s_last%0d", tag, k), DW'(beat_last[k]), DW'(k == len - 1));
            if (consec) chk($sformatf("%s_cyc%0d", tag, k), DW'(beat_cyc[k]), DW'(4 + k));
        end
        chk({tag, "_done_cnt"}, DW'(done_cnt), DW'(1));
        if (beat_cyc.size() > 0)
            chk({tag, "_done_cyc"}, DW'(done_cyc), DW'(beat_cyc[beat_cyc.size() - 1] + 1));
        chk({tag, "_init_cnt"}, DW'(init_cnt), DW'(1));
        chk({tag, "_rd_cnt"}, DW'(rd_cnt), DW'(len));
        chk({tag, "_outstanding"}, DW'(out_err), '0);
        chk({tag, "_stable"}, DW'(stab_err), '0);
        chk({tag, "_strobe_pair"}, DW'(pair_err), '0);
        chk({tag, "_idle_after"}, DW'(busy), '0);
    endtask

    task automatic fill_const(input logic [AW-1:0] a);
        for (int k = 0; k < 128; k++) addr_seq[k] = a;
    endtask

    task automatic fill_stream();
        int k = 0;
        fill_const('0);
        for (int j = 0; j < 3; j++)
            for (int i = 0; i < 4; i++) begin
                addr_seq[k] = AW'('h100 + 'h20 * j + i);
                k++;
            end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; cfg_len = '0; bus.dout_ready = 1'b0;
        fill_const('0);
        repeat (2) @(posedge clk);
        @(negedge clk) chk_zero("reset");
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk) chk_zero("post_reset");
        @(posedge clk); #1;

        fill_const(AW'('h010));
        do_run("single", 1, 0, 0, -1);
        chk_beats("single", 1, 1);
        chk("single_done_at5", DW'(done_cyc), DW'(5));
        chk("single_busy_until5", DW'(last_busy_cyc), DW'(5));

        fill_stream();
        do_run("stream", 12, 0, 0, -1);
        chk_beats("stream", 12, 1);

        do_run("bp", 12, 1, 0, -1);
        chk_beats("bp", 12, 0);
        chk("bp_max_outstanding", DW'(max_out), DW'(DEPTH));
        chk("bp_reads_by12", DW'(rd_at12), DW'(DEPTH));

        do_run("zero", 0, 0, 0, -1);
        chk("zero_beats", DW'(beat_data.size()), '0);
        chk("zero_rd", DW'(rd_cnt), '0);
        chk("zero_init", DW'(init_cnt), DW'(1));
        chk("zero_done_cyc", DW'(done_cyc), DW'(2));
        chk("zero_done_cnt", DW'(done_cnt), DW'(1));

        do_run("restart", 12, 0, 1, -1);
        chk_beats("restart", 12, 1);

        do_run("midrst", 12, 0, 0, 9);
        chk("midrst_beats_before", DW'(beat_data.size()), DW'(5));
        rst_n = 1'b0;
        @(negedge clk) chk_zero("midrst_in_reset");
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk) chk_zero("midrst_after");
        @(posedge clk); #1;
        do_run("midrst_again", 2, 0, 0, -1);
        chk_beats("midrst_again", 2, 1);

        for (int it = 0; it < 8; it++) begin
            int len = $urandom_range(1, 24);
            for (int k = 0; k < 128; k++) addr_seq[k] = AW'($urandom);
            do_run($sformatf("rand%0d", it), len, (it % 2 == 0) ? 0 : 2, 0, -1);
            chk_beats($sformatf("rand%0d", it), len, it % 2 == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
